// File: rtl/async_down_counter_pkg.sv
// Shared constants and helpers for the ripple down-counter and its bench.
// Widths run from 1 to MAX_WIDTH toggle stages.
package async_cnt_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_WIDTH     = 16;

    // All-ones value the counter wraps to from zero, for a given stage count.
    function automatic logic [15:0] wrap_value(input int unsigned width);
        logic [16:0] span_s;
        span_s = 17'd1 << width;
        return 16'(span_s - 17'd1);
    endfunction

endpackage

// File: rtl/async_down_counter_if.sv
// Count bus of the ripple down-counter; the counter drives it, consumers read it.
interface async_down_counter_if
    import async_cnt_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] q;

    modport master (output q);
    modport slave  (input  q);

endinterface

// File: rtl/async_down_counter_t_ff.sv
// Single toggle stage: flips on every rising edge of its own clock and has
// its own asynchronous active-low clear, so no logic is shared between stages.
module t_ff (
    input  logic clk,
    input  logic rst,
    output logic q
);

    logic q_r;

    // Toggle flop with asynchronous clear dominating the clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r <= 1'b0;
        end else begin
            q_r <= ~q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/async_down_counter.sv
// Ripple binary down-counter: a chain of toggle stages where each stage is
// clocked by the rising edge (borrow) of the stage below it.
module async_down_counter
    import async_cnt_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    async_down_counter_if.master  cnt
);

    logic [WIDTH-1:0] q_r;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        logic stage_clk_s;

        // A 0->1 transition of the lower bit is the borrow that clocks this one.
        if (i == 0) begin : g_lsb
            assign stage_clk_s = clk;
        end else begin : g_upper
            assign stage_clk_s = q_r[i-1];
        end

        t_ff u_tff (
            .clk (stage_clk_s),
            .rst (rst),
            .q   (q_r[i])
        );
    end

    assign cnt.q = q_r;

endmodule

// File: tb/tb_async_down_counter.sv
// Randomised scoreboard bench for the ripple down-counter at widths 4, 1 and 8.
module tb_async_down_counter;
    import async_cnt_pkg::*;

    typedef struct {
        string tag;
        int    e4;
        int    e1;
        int    e8;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    async_down_counter_if #(.WIDTH(4)) if4 ();
    async_down_counter_if #(.WIDTH(1)) if1 ();
    async_down_counter_if #(.WIDTH(8)) if8 ();

    async_down_counter #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .cnt(if4.master));
    async_down_counter #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .cnt(if1.master));
    async_down_counter #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .cnt(if8.master));

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    event chk_ev;
    int   n_edges  = 0;
    bit   running  = 1'b0;

    // Reference: after n counted edges the value is -n modulo 2^width.
    function automatic int ref_value(input int n, input int w);
        int m;
        m = int'(wrap_value(w)) + 1;
        return (m - (n % m)) % m;
    endfunction

    task automatic push(input string tag);
        exp_t e;
        e.tag = tag;
        e.e4  = ref_value(n_edges, 4);
        e.e1  = ref_value(n_edges, 1);
        e.e8  = ref_value(n_edges, 8);
        sb_q.push_back(e);
        -> chk_ev;
    endtask

    task automatic run_edges(input int k, input string tag);
        repeat (k) begin
            @(posedge clk);
            if (running) n_edges++;
            #1;
            push(tag);
        end
    endtask

    // Called at posedge+1; offset keeps the action strictly between edges.
    task automatic do_reset(input int offset);
        #(offset - 1);
        rst     = 1'b0;
        running = 1'b0;
        n_edges = 0;
        #1;
        push("async_clear");
    endtask

    task automatic release_rst(input int offset);
        #(offset - 1);
        rst     = 1'b1;
        running = 1'b1;
        n_edges = 0;
        #1;
        push("released");
    endtask

    task automatic check(input string tag, input int w, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s width=%0d q=%0d expected=%0d", tag, w, got, exp);
        end
    endtask

    // Monitor: pops every pending expectation and compares against the DUTs.
    initial begin
        forever begin
            @(chk_ev);
            while (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check(e.tag, 4, int'(if4.q), e.e4);
                check(e.tag, 1, int'(if1.q), e.e1);
                check(e.tag, 8, int'(if8.q), e.e8);
            end
        end
    end

    // Stimulus.
    initial begin
        #1;
        rst = 1'b0;
        #1;
        push("reset_immediate");
        run_edges(2, "reset_hold");
        release_rst(3);
        run_edges(20, "count_wrap");

        do_reset(4);
        run_edges(2, "clear_hold");
        release_rst(5);
        run_edges(7, "to_nine");
        do_reset(4);
        run_edges(2, "mid_clear_hold");
        release_rst(3);
        run_edges(1, "after_clear");
        run_edges(259, "long_run");

        repeat (6) begin
            run_edges(int'($urandom_range(1, 40)), "rand_run");
            do_reset(int'($urandom_range(2, 8)));
            run_edges(int'($urandom_range(1, 3)), "rand_hold");
            release_rst(int'($urandom_range(2, 8)));
        end
        run_edges(5, "tail");

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) #1;
        if (sb_q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog time=%0t limit=200000", $time);
        $fatal(1, "timeout");
    end

endmodule
